// File: rtl/fsmc_fifo_regs_pkg.sv
// Shared register map and bit positions for the FSMC FIFO register block.
package fsmc_fifo_regs_pkg;

  localparam int unsigned REG_DATA     = 0;
  localparam int unsigned REG_STATUS   = 1;
  localparam int unsigned REG_RX_COUNT = 2;
  localparam int unsigned REG_CONTROL  = 3;

  localparam int unsigned ST_RX_EMPTY     = 0;
  localparam int unsigned ST_RX_FULL      = 1;
  localparam int unsigned ST_TX_EMPTY     = 2;
  localparam int unsigned ST_TX_FULL      = 3;
  localparam int unsigned ST_TX_OVERFLOW  = 4;
  localparam int unsigned ST_RX_UNDERFLOW = 5;

  localparam int unsigned CTL_FLUSH_RX = 0;
  localparam int unsigned CTL_FLUSH_TX = 1;

endpackage

// File: rtl/fsmc_fifo_regs_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; flush overrides push/pop.
module sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [1<<AW];
  logic         do_push;
  logic         do_pop;

  // Push/pop are judged on pre-edge state, so an empty FIFO never falls through.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/fsmc_fifo_regs.sv
// FSMC register map bridging the bus slave to fabric TX/RX FIFOs.
module fsmc_fifo_regs
  import fsmc_fifo_regs_pkg::*;
#(
  parameter int unsigned ADRW    = 2,
  parameter int unsigned DATW    = 8,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            do_write,
  input  logic            do_read,
  input  logic [ADRW-1:0] rw_adr,
  input  logic [DATW-1:0] w_data,
  output logic [DATW-1:0] read_data,
  output logic            tx_valid,
  output logic [DATW-1:0] tx_data,
  input  logic            tx_ready,
  input  logic            rx_valid,
  input  logic [DATW-1:0] rx_data,
  output logic            rx_ready
);

  logic              tx_empty, tx_full, rx_empty, rx_full;
  logic [FIFO_AW:0]  tx_count, rx_count;
  logic [DATW-1:0]   rx_head;
  logic              tx_overflow, rx_underflow;
  logic              wr_data, rd_data, rd_status, wr_control;
  logic              flush_rx, flush_tx;

  assign wr_data    = do_write & (rw_adr == ADRW'(REG_DATA));
  assign wr_control = do_write & (rw_adr == ADRW'(REG_CONTROL));
  assign rd_data    = do_read  & (rw_adr == ADRW'(REG_DATA));
  assign rd_status  = do_read  & (rw_adr == ADRW'(REG_STATUS));
  assign flush_rx   = wr_control & w_data[CTL_FLUSH_RX];
  assign flush_tx   = wr_control & w_data[CTL_FLUSH_TX];

  sync_fifo #(.W(DATW), .AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (wr_data),
    .pop   (tx_ready),
    .flush (flush_tx),
    .din   (w_data),
    .dout  (tx_data),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  sync_fifo #(.W(DATW), .AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (rx_valid),
    .pop   (rd_data),
    .flush (flush_rx),
    .din   (rx_data),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  // A new error in the same cycle as a clearing STATUS read keeps the flag set.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      tx_overflow  <= (tx_overflow  & ~rd_status) | (wr_data & tx_full);
      rx_underflow <= (rx_underflow & ~rd_status) | (rd_data & rx_empty);
    end
  end

  always_comb begin
    read_data = '0;
    case (rw_adr)
      ADRW'(REG_DATA):     read_data = rx_empty ? '0 : rx_head;
      ADRW'(REG_STATUS): begin
        read_data[ST_RX_EMPTY]     = rx_empty;
        read_data[ST_RX_FULL]      = rx_full;
        read_data[ST_TX_EMPTY]     = tx_empty;
        read_data[ST_TX_FULL]      = tx_full;
        read_data[ST_TX_OVERFLOW]  = tx_overflow;
        read_data[ST_RX_UNDERFLOW] = rx_underflow;
      end
      ADRW'(REG_RX_COUNT): read_data[FIFO_AW:0] = rx_count;
      default:             read_data = '0;
    endcase
  end

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  tx_count_consistent: assert property (@(posedge clk) disable iff (!nrst)
    tx_empty == (tx_count == '0));

endmodule

// File: tb/tb_fsmc_fifo_regs.sv
// Scoreboard bench: bus reads and TX drains are checked by a negedge monitor.
module tb_fsmc_fifo_regs;

  localparam int unsigned ADRW = 2;
  localparam int unsigned DATW = 8;
  localparam int unsigned FAW  = 4;

  logic            clk = 1'b0;
  logic            nrst;
  logic            do_write, do_read;
  logic [ADRW-1:0] rw_adr;
  logic [DATW-1:0] w_data, read_data, tx_data, rx_data;
  logic            tx_valid, tx_ready, rx_valid, rx_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [DATW-1:0] rd_q[$];
  logic [DATW-1:0] tx_q[$];

  always #5 clk = ~clk;

  fsmc_fifo_regs #(.ADRW(ADRW), .DATW(DATW), .FIFO_AW(FAW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .do_write  (do_write),
    .do_read   (do_read),
    .rw_adr    (rw_adr),
    .w_data    (w_data),
    .read_data (read_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (do_read) begin
      if (rd_q.size() == 0) check("unexpected_read", 32'(read_data), 32'hDEAD);
      else check("read_data", 32'(read_data), 32'(rd_q.pop_front()));
    end
    if (nrst && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) check("unexpected_tx_pop", 32'(tx_data), 32'hDEAD);
      else check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [ADRW-1:0] adr, input logic [DATW-1:0] d);
    do_write = 1'b1; rw_adr = adr; w_data = d;
    tick();
    do_write = 1'b0;
  endtask

  task automatic bus_read(input logic [ADRW-1:0] adr, input logic [DATW-1:0] exp);
    do_read = 1'b1; rw_adr = adr;
    rd_q.push_back(exp);
    tick();
    do_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = 1'b0; do_write = 1'b0; do_read = 1'b0; rw_adr = '0; w_data = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tick(); tick();
    nrst = 1'b1;
    tick();

    // reset state
    check("reset_tx_valid", 32'(tx_valid), 0);
    check("reset_rx_ready", 32'(rx_ready), 1);
    bus_read(2'd1, 8'h05);

    // basic TX path
    bus_write(2'd0, 8'h11);
    bus_write(2'd0, 8'h22);
    bus_write(2'd0, 8'h33);
    check("tx_valid_after_writes", 32'(tx_valid), 1);
    check("tx_head", 32'(tx_data), 32'h11);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
    tx_ready = 1'b1;
    repeat (3) tick();
    tx_ready = 1'b0;
    check("tx_drained", 32'(tx_valid), 0);

    // TX overflow: 17th write dropped
    for (int i = 0; i < 17; i++) bus_write(2'd0, 8'(8'h40 + i));
    bus_read(2'd1, 8'h19);
    bus_read(2'd1, 8'h09);
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(8'h40 + i));
    tx_ready = 1'b1;
    repeat (16) tick();
    tx_ready = 1'b0;
    check("tx_empty_after_overflow_drain", 32'(tx_valid), 0);

    // RX path and underflow
    rx_valid = 1'b1; rx_data = 8'hA5; tick();
    rx_data = 8'h5A; tick();
    rx_valid = 1'b0;
    bus_read(2'd2, 8'd2);
    bus_read(2'd0, 8'hA5);
    bus_read(2'd0, 8'h5A);
    bus_read(2'd0, 8'h00);
    bus_read(2'd1, 8'h25);
    bus_read(2'd1, 8'h05);

    // RX full boundary with backpressure release
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h80 + i);
      tick();
    end
    rx_data = 8'hEE;
    check("rx_ready_full", 32'(rx_ready), 0);
    bus_read(2'd1, 8'h06);
    bus_read(2'd0, 8'h80);
    check("rx_ready_after_pop", 32'(rx_ready), 1);
    tick();
    rx_valid = 1'b0;
    bus_read(2'd2, 8'd16);
    for (int i = 1; i < 16; i++) bus_read(2'd0, 8'(8'h80 + i));
    bus_read(2'd0, 8'hEE);
    bus_read(2'd2, 8'd0);

    // flush both FIFOs while the fabric pushes RX in the same cycle
    bus_write(2'd0, 8'h01);
    bus_write(2'd0, 8'h02);
    rx_valid = 1'b1; rx_data = 8'h77; tick();
    do_write = 1'b1; rw_adr = 2'd3; w_data = 8'h03; rx_data = 8'h99;
    tick();
    do_write = 1'b0; rx_valid = 1'b0;
    check("tx_valid_after_flush", 32'(tx_valid), 0);
    check("rx_ready_after_flush", 32'(rx_ready), 1);
    bus_read(2'd2, 8'd0);
    bus_read(2'd3, 8'h00);
    bus_read(2'd1, 8'h05);

    // asynchronous reset mid-drain
    bus_write(2'd0, 8'h31);
    bus_write(2'd0, 8'h32);
    bus_write(2'd0, 8'h33);
    tx_q.push_back(8'h31);
    tx_ready = 1'b1;
    tick();
    check("tx_valid_mid_drain", 32'(tx_valid), 1);
    nrst = 1'b0;
    #1;
    check("tx_valid_async_reset", 32'(tx_valid), 0);
    check("rx_ready_async_reset", 32'(rx_ready), 1);
    tx_ready = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    bus_read(2'd1, 8'h05);

    check("rd_queue_drained", 32'(rd_q.size()), 0);
    check("tx_queue_drained", 32'(tx_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
